// File: rtl/spi_frame_writer.sv
// rtl/spi_frame_writer.sv - decodes spi_slave byte stream into WS2812B framebuffer writes
// Optional brightness scaling: define SPI_FRAME_WRITER_BRIGHTNESS_EN.
module spi_frame_writer #(
   parameter int NUM_LEDS = 64,
   parameter int ADDR_W   = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              rx_first,
   input  logic              rx_idle,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [23:0]       fb_wdata,
   output logic              show,
   output logic              cmd_err
);

   localparam logic [7:0]        CMD_WRITE = 8'h01;
   localparam logic [7:0]        CMD_SHOW  = 8'h02;
   localparam logic [15:0]       LED_LIMIT = 16'(NUM_LEDS);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_LEDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR_HI,
      S_ADDR_LO,
      S_PIX,
      S_DISCARD
`ifdef SPI_FRAME_WRITER_BRIGHTNESS_EN
      , S_BRIGHT
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] index_q, index_d;
   logic [7:0]        addr_hi_q, addr_hi_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [7:0]        g_q, g_d;
   logic [7:0]        r_q, r_d;
   logic              fb_we_q, fb_we_d;
   logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
   logic [23:0]       fb_wdata_q, fb_wdata_d;
   logic              show_q, show_d;
   logic              cmd_err_q, cmd_err_d;
   logic [15:0]       addr_full;
   logic [23:0]       pixel;

   assign addr_full = {addr_hi_q, rx_data};

`ifdef SPI_FRAME_WRITER_BRIGHTNESS_EN
   localparam logic [7:0] CMD_BRIGHT = 8'h03;
   logic [7:0] bright_q, bright_d;

   // (c * (B+1)) >> 8, so B = 0xFF leaves the channel untouched
   function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
      logic [16:0] p;
      p = 17'(c) * 17'({1'b0, b} + 9'd1);
      return p[15:8];
   endfunction

   assign pixel = {scale(g_q, bright_q), scale(r_q, bright_q), scale(rx_data, bright_q)};
`else
   assign pixel = {g_q, r_q, rx_data};
`endif

   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      addr_hi_d  = addr_hi_q;
      cnt_d      = cnt_q;
      g_d        = g_q;
      r_d        = r_q;
      fb_we_d    = 1'b0;
      fb_addr_d  = fb_addr_q;
      fb_wdata_d = fb_wdata_q;
      show_d     = 1'b0;
      cmd_err_d  = 1'b0;
`ifdef SPI_FRAME_WRITER_BRIGHTNESS_EN
      bright_d   = bright_q;
`endif
      // Idle beats any byte arriving in the same cycle
      if (rx_idle) begin
         state_d = S_IDLE;
         cnt_d   = 2'd0;
      end else if (rx_valid && rx_first) begin
         cnt_d = 2'd0;
         case (rx_data)
            CMD_WRITE: state_d = S_ADDR_HI;
            CMD_SHOW: begin
               show_d  = 1'b1;
               state_d = S_DISCARD;
            end
`ifdef SPI_FRAME_WRITER_BRIGHTNESS_EN
            CMD_BRIGHT: state_d = S_BRIGHT;
`endif
            default: begin
               cmd_err_d = 1'b1;
               state_d   = S_DISCARD;
            end
         endcase
      end else if (rx_valid) begin
         case (state_q)
            S_ADDR_HI: begin
               addr_hi_d = rx_data;
               state_d   = S_ADDR_LO;
            end
            S_ADDR_LO: begin
               if (addr_full >= LED_LIMIT) begin
                  cmd_err_d = 1'b1;
                  state_d   = S_DISCARD;
               end else begin
                  index_d = addr_full[ADDR_W-1:0];
                  state_d = S_PIX;
               end
            end
            S_PIX: begin
               case (cnt_q)
                  2'd0: begin
                     g_d   = rx_data;
                     cnt_d = 2'd1;
                  end
                  2'd1: begin
                     r_d   = rx_data;
                     cnt_d = 2'd2;
                  end
                  default: begin
                     fb_we_d    = 1'b1;
                     fb_addr_d  = index_q;
                     fb_wdata_d = pixel;
                     index_d    = (index_q == LAST_IDX) ? '0 : index_q + 1'b1;
                     cnt_d      = 2'd0;
                  end
               endcase
            end
`ifdef SPI_FRAME_WRITER_BRIGHTNESS_EN
            S_BRIGHT: begin
               bright_d = rx_data;
               state_d  = S_DISCARD;
            end
`endif
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         index_q    <= '0;
         addr_hi_q  <= '0;
         cnt_q      <= '0;
         g_q        <= '0;
         r_q        <= '0;
         fb_we_q    <= 1'b0;
         fb_addr_q  <= '0;
         fb_wdata_q <= '0;
         show_q     <= 1'b0;
         cmd_err_q  <= 1'b0;
`ifdef SPI_FRAME_WRITER_BRIGHTNESS_EN
         bright_q   <= 8'hFF;
`endif
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         addr_hi_q  <= addr_hi_d;
         cnt_q      <= cnt_d;
         g_q        <= g_d;
         r_q        <= r_d;
         fb_we_q    <= fb_we_d;
         fb_addr_q  <= fb_addr_d;
         fb_wdata_q <= fb_wdata_d;
         show_q     <= show_d;
         cmd_err_q  <= cmd_err_d;
`ifdef SPI_FRAME_WRITER_BRIGHTNESS_EN
         bright_q   <= bright_d;
`endif
      end
   end

   assign fb_we    = fb_we_q;
   assign fb_addr  = fb_addr_q;
   assign fb_wdata = fb_wdata_q;
   assign show     = show_q;
   assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_frame_writer.sv
// tb/tb_spi_frame_writer.sv - directed self-checking bench for spi_frame_writer
`timescale 1ns/1ps
module tb_spi_frame_writer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_first = 1'b0;
   logic        rx_idle = 1'b0;
   logic        fb_we;
   logic [5:0]  fb_addr;
   logic [23:0] fb_wdata;
   logic        show;
   logic        cmd_err;

   int checks = 0;
   int errors = 0;
   int we_cnt = 0;
   int show_cnt = 0;
   int err_cnt = 0;
   logic        c_we;
   logic [5:0]  c_addr;
   logic [23:0] c_data;
   logic        c_show;
   logic        c_err;

   spi_frame_writer #(.NUM_LEDS(64), .ADDR_W(6)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_first(rx_first), .rx_idle(rx_idle), .fb_we(fb_we), .fb_addr(fb_addr),
      .fb_wdata(fb_wdata), .show(show), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end

   task automatic grab();
      c_we   = fb_we;
      c_addr = fb_addr;
      c_data = fb_wdata;
      c_show = show;
      c_err  = cmd_err;
      if (fb_we)   we_cnt++;
      if (show)    show_cnt++;
      if (cmd_err) err_cnt++;
   endtask

   task automatic send(input logic [7:0] d, input logic f);
      rx_data  = d;
      rx_valid = 1'b1;
      rx_first = f;
      @(negedge clk);
      grab();
   endtask

   task automatic gap();
      rx_valid = 1'b0;
      rx_first = 1'b0;
      @(negedge clk);
      grab();
   endtask

   task automatic clr();
      we_cnt = 0; show_cnt = 0; err_cnt = 0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      `CHK("rst_we", fb_we, 1'b0)
      `CHK("rst_addr", fb_addr, 6'h00)
      `CHK("rst_data", fb_wdata, 24'h000000)
      `CHK("rst_show", show, 1'b0)
      `CHK("rst_err", cmd_err, 1'b0)
      reset = 1'b0;
      gap();

      // T2 basic write with back-to-back bytes
      clr();
      send(8'h01, 1'b1);
      `CHK("t2_cmd_noerr", c_err, 1'b0)
      send(8'h00, 1'b0);
      send(8'h05, 1'b0);
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      `CHK("t2_no_early_we", c_we, 1'b0)
      send(8'h33, 1'b0);
      `CHK("t2_we0", c_we, 1'b1)
      `CHK("t2_addr0", c_addr, 6'd5)
      `CHK("t2_data0", c_data, 24'h112233)
      send(8'h44, 1'b0);
      `CHK("t2_we_pulse", c_we, 1'b0)
      send(8'h55, 1'b0);
      send(8'h66, 1'b0);
      `CHK("t2_addr1", c_addr, 6'd6)
      `CHK("t2_data1", c_data, 24'h445566)
      gap();
      `CHK("t2_we_cnt", we_cnt, 2)

      // T3 index wrap 63 -> 0
      clr();
      send(8'h01, 1'b1); send(8'h00, 1'b0); send(8'h3F, 1'b0);
      send(8'hFF, 1'b0); send(8'h00, 1'b0); send(8'h01, 1'b0);
      `CHK("t3_addr63", c_addr, 6'd63)
      `CHK("t3_data63", c_data, 24'hFF0001)
      send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
      `CHK("t3_addr0", c_addr, 6'd0)
      `CHK("t3_data0", c_data, 24'h020304)
      gap();
      `CHK("t3_we_cnt", we_cnt, 2)

      // T1 reset mid-PIX: third byte in flight when reset hits
      clr();
      send(8'h01, 1'b1); send(8'h00, 1'b0); send(8'h00, 1'b0);
      send(8'h11, 1'b0); send(8'h22, 1'b0);
      rx_data = 8'h33; rx_valid = 1'b1; rx_first = 1'b0;
      #2 reset = 1'b1;
      #1;
      `CHK("t1_rst_data", fb_wdata, 24'h000000)
      `CHK("t1_rst_addr", fb_addr, 6'h00)
      @(negedge clk);
      grab();
      `CHK("t1_rst_we", c_we, 1'b0)
      rx_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'h05, 1'b0);
      send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
      gap();
      `CHK("t1_no_we", we_cnt, 0)
      `CHK("t1_no_err", err_cnt, 0)

      // T4 idle abort, idle wins over a coincident byte
      clr();
      send(8'h01, 1'b1); send(8'h00, 1'b0); send(8'h02, 1'b0);
      send(8'hAA, 1'b0); send(8'hBB, 1'b0);
      rx_idle = 1'b1;
      send(8'hCC, 1'b0);
      rx_idle = 1'b0;
      send(8'hDD, 1'b0); send(8'hEE, 1'b0); send(8'hFF, 1'b0);
      gap();
      `CHK("t4_no_we", we_cnt, 0)
      send(8'h01, 1'b1); send(8'h00, 1'b0); send(8'h02, 1'b0);
      send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h56, 1'b0);
      `CHK("t4_addr", c_addr, 6'd2)
      `CHK("t4_data", c_data, 24'h123456)
      gap();
      `CHK("t4_we_cnt", we_cnt, 1)

      // T5 unknown command and out-of-range start index
      clr();
      send(8'h07, 1'b1);
      `CHK("t5_err_cmd", c_err, 1'b1)
      send(8'h01, 1'b0);
      `CHK("t5_err_pulse", c_err, 1'b0)
      send(8'h00, 1'b0); send(8'h00, 1'b0);
      send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
      send(8'h01, 1'b1); send(8'h00, 1'b0); send(8'h40, 1'b0);
      `CHK("t5_err_range", c_err, 1'b1)
      send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
      gap();
      `CHK("t5_no_we", we_cnt, 0)
      `CHK("t5_err_cnt", err_cnt, 2)

      // T6 show, including a show command cutting a partial pixel
      clr();
      send(8'h01, 1'b1); send(8'h00, 1'b0); send(8'h01, 1'b0); send(8'hAA, 1'b0);
      send(8'h02, 1'b1);
      `CHK("t6_show", c_show, 1'b1)
      send(8'h99, 1'b0);
      `CHK("t6_show_pulse", c_show, 1'b0)
      send(8'h98, 1'b0);
      gap();
      `CHK("t6_no_we", we_cnt, 0)
      `CHK("t6_show_cnt", show_cnt, 1)
`ifdef SPI_FRAME_WRITER_BRIGHTNESS_EN
      clr();
      send(8'h03, 1'b1);
      `CHK("t6_bright_noerr", c_err, 1'b0)
      send(8'h80, 1'b0);
      send(8'h01, 1'b1); send(8'h00, 1'b0); send(8'h00, 1'b0);
      send(8'hFF, 1'b0); send(8'h80, 1'b0); send(8'h00, 1'b0);
      `CHK("t6_bright_we", c_we, 1'b1)
      `CHK("t6_bright_data", c_data, 24'h804000)
`else
      send(8'h03, 1'b1);
      `CHK("t6_cmd03_err", c_err, 1'b1)
`endif
      gap();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
